load_store_unit: RTL and testbench

- Memory-access initiator that sits between the core's MEM stage and the word-wide, single-port data RAM.
- The data RAM has a registered 1-cycle read, no byte enables, and a word-indexed address.
- This block converts RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) at byte addresses into RAM read, write and read-modify-write sequences.
- It returns sign- or zero-extended load data with a done pulse.

---
 rtl/load_store_unit.sv | 168 ++++++++++++++++
 tb/tb_load_store_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer in front of a word-wide, single-port RAM with 1-cycle read latency.
// Sub-word stores are done as read-modify-write because the RAM has no byte enables.
`timescale 1ns/1ps
module load_store_unit #(
    parameter int unsigned width     = 32,
    parameter int unsigned addrWidth = 8
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 req,
    input  logic                 we,
    input  logic [2:0]           funct3,
    input  logic [31:0]          addr,
    input  logic [width-1:0]     wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [width-1:0]     rdata,
    output logic [addrWidth-1:0] mem_addr,
    output logic [width-1:0]     mem_din,
    output logic                 mem_wren,
    input  logic [width-1:0]     mem_dout
);

    typedef enum logic [2:0] {StIdle, StRead, StCapture, StMerge, StWrite} state_e;

    state_e               state_q, state_d;
    logic                 we_q, we_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [1:0]           off_q, off_d;
    logic [width-1:0]     wdata_q, wdata_d;
    logic [width-1:0]     rdata_q, rdata_d;
    logic [width-1:0]     mem_din_q, mem_din_d;
    logic [addrWidth-1:0] mem_addr_q, mem_addr_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 legal;
    logic [4:0]           shamt;
    logic [width-1:0]     lane;
    logic [width-1:0]     load_val;
    logic [width-1:0]     mask;
    logic [width-1:0]     merged;
    logic                 unused_addr_hi;

    // Word addresses wrap: bits above the RAM index are dropped.
    assign unused_addr_hi = ^addr[31:addrWidth+2];

    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~addr[0];
            3'b010:  legal = (addr[1:0] == 2'b00);
            3'b100:  legal = ~we;
            3'b101:  legal = ~we & ~addr[0];
            default: legal = 1'b0;
        endcase
    end

    // Byte/halfword lane selected by the latched offset; halfwords are already 2-aligned.
    assign shamt = {off_q, 3'b000};
    assign lane  = mem_dout >> shamt;

    always_comb begin
        load_val = mem_dout;
        case (funct3_q)
            3'b000:  load_val = {{(width-8){lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{(width-16){lane[15]}}, lane[15:0]};
            3'b100:  load_val = {{(width-8){1'b0}}, lane[7:0]};
            3'b101:  load_val = {{(width-16){1'b0}}, lane[15:0]};
            default: load_val = mem_dout;
        endcase
    end

    always_comb begin
        if (funct3_q[0]) begin
            mask = {{(width-16){1'b0}}, 16'hFFFF} << shamt;
        end else begin
            mask = {{(width-8){1'b0}}, 8'hFF} << shamt;
        end
        merged = (mem_dout & ~mask) | ((wdata_q << shamt) & mask);
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        mem_din_d  = mem_din_q;
        mem_addr_d = mem_addr_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    we_d       = we;
                    funct3_d   = funct3;
                    off_d      = addr[1:0];
                    wdata_d    = wdata;
                    mem_addr_d = addr[addrWidth+1:2];
                    if (!legal) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (we && funct3 == 3'b010) begin
                        mem_din_d = wdata;
                        state_d   = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead:    state_d = we_q ? StMerge : StCapture;
            StCapture: begin
                rdata_d = load_val;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            StMerge: begin
                mem_din_d = merged;
                state_d   = StWrite;
            end
            StWrite: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            off_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            mem_din_q  <= '0;
            mem_addr_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            mem_din_q  <= mem_din_d;
            mem_addr_q <= mem_addr_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Decoded from state so an async clear cuts the write strobe immediately.
    assign mem_wren = (state_q == StWrite);
    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural RAM, vector table with a result scoreboard,
// plus hand sequences for clear-during-merge and held-request throughput.
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int W  = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          clear;
    logic          req;
    logic          we;
    logic [2:0]    funct3;
    logic [31:0]   addr;
    logic [W-1:0]  wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [W-1:0]  rdata;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_din;
    logic          mem_wren;
    logic [W-1:0]  mem_dout;

    load_store_unit #(.width(W), .addrWidth(AW)) dut (
        .clk(clk), .clear(clear), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wren(mem_wren), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    logic [W-1:0] ram [256] = '{1: 32'h11111111, 2: 32'h22222222, 3: 32'h33333333,
                                5: 32'h8899AABB, default: 32'h0};

    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wren_cyc;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] val;
        int          due;
    } bb_t;

    exp_t sb_q[$];
    bb_t  bb_q[$];
    vec_t vecs[17];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one access at #1 after an edge (cycle 0) and follow it to its done pulse.
    task automatic run_op(input vec_t v);
        exp_t e;
        int   cyc;
        int   wren_n;
        int   wren_at;
        bit   seen;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.lat   = v.exp_lat;
        sb_q.push_back(e);
        req = 1'b1; we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; funct3 = 3'b0; addr = 32'h0; wdata = '0;
        cyc = 1; wren_n = 0; wren_at = 0; seen = 1'b0;
        while (cyc <= 8 && !seen) begin
            if (mem_wren) begin
                wren_n++;
                wren_at = cyc;
            end
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        e = sb_q.pop_front();
        if (!seen) begin
            check("done_timeout", 32'(cyc), 32'(e.lat));
        end else begin
            check("done_latency", 32'(cyc), 32'(e.lat));
            check("err", 32'(err), 32'(e.err));
            check("rdata", rdata, e.rdata);
            check("busy_at_done", 32'(busy), 32'(0));
            check("mem_addr", 32'(mem_addr), {24'h0, v.addr[9:2]});
        end
        check("wren_count", 32'(wren_n), (v.exp_wren_cyc != 0) ? 32'd1 : 32'd0);
        check("wren_cycle", 32'(wren_at), 32'(v.exp_wren_cyc));
        @(posedge clk); #1;
        check("done_width", 32'(done), 32'(0));
        check("err_width", 32'(err), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] words [4];
        int          cnt;

        //          we    f3      addr       wdata        exp_rdata    err   lat wren
        vecs[0]  = '{1'b0, 3'b000, 32'h15,    32'h0,        32'hFFFFFFAA, 1'b0, 3, 0};
        vecs[1]  = '{1'b0, 3'b100, 32'h17,    32'h0,        32'h00000088, 1'b0, 3, 0};
        vecs[2]  = '{1'b0, 3'b001, 32'h16,    32'h0,        32'hFFFF8899, 1'b0, 3, 0};
        vecs[3]  = '{1'b0, 3'b010, 32'h14,    32'h0,        32'h8899AABB, 1'b0, 3, 0};
        vecs[4]  = '{1'b1, 3'b000, 32'h14,    32'h12345677, 32'h8899AABB, 1'b0, 4, 3};
        vecs[5]  = '{1'b0, 3'b010, 32'h14,    32'h0,        32'h8899AA77, 1'b0, 3, 0};
        vecs[6]  = '{1'b1, 3'b001, 32'h16,    32'h0000BEEF, 32'h8899AA77, 1'b0, 4, 3};
        vecs[7]  = '{1'b0, 3'b010, 32'h14,    32'h0,        32'hBEEFAA77, 1'b0, 3, 0};
        vecs[8]  = '{1'b0, 3'b101, 32'h16,    32'h0,        32'h0000BEEF, 1'b0, 3, 0};
        vecs[9]  = '{1'b0, 3'b000, 32'h14,    32'h0,        32'h00000077, 1'b0, 3, 0};
        vecs[10] = '{1'b1, 3'b010, 32'h400,   32'hCAFEF00D, 32'h00000077, 1'b0, 2, 1};
        vecs[11] = '{1'b0, 3'b010, 32'h400,   32'h0,        32'hCAFEF00D, 1'b0, 3, 0};
        vecs[12] = '{1'b1, 3'b010, 32'h22,    32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 1, 0};
        vecs[13] = '{1'b0, 3'b001, 32'h13,    32'h0,        32'hCAFEF00D, 1'b1, 1, 0};
        vecs[14] = '{1'b0, 3'b011, 32'h14,    32'h0,        32'hCAFEF00D, 1'b1, 1, 0};
        vecs[15] = '{1'b1, 3'b100, 32'h14,    32'h000000EE, 32'hCAFEF00D, 1'b1, 1, 0};
        vecs[16] = '{1'b0, 3'b010, 32'h14,    32'h0,        32'hBEEFAA77, 1'b0, 3, 0};

        clear = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b0; addr = 32'h0; wdata = '0;
        #2 clear = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_din", mem_din, 32'h0);
        check("rst_mem_wren", 32'(mem_wren), 32'(0));
        clear = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) run_op(vecs[i]);
        check("ram0_after_wrapped_sw", ram[0], 32'hCAFEF00D);
        check("ram8_untouched_by_err", ram[8], 32'h0);
        check("ram5_untouched_by_err", ram[5], 32'hBEEFAA77);

        // Clear while the SB sits in MERGE: the write must never happen.
        req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h14; wdata = 32'h00000055;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        check("rmw_busy_read", 32'(busy), 32'(1));
        @(posedge clk); #1;
        check("rmw_busy_merge", 32'(busy), 32'(1));
        clear = 1'b1;
        #1;
        check("clr_mem_wren", 32'(mem_wren), 32'(0));
        check("clr_busy", 32'(busy), 32'(0));
        check("clr_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("clr_no_write", 32'(mem_wren), 32'(0));
            @(posedge clk); #1;
        end
        check("clr_ram5_kept", ram[5], 32'hBEEFAA77);
        run_op('{1'b0, 3'b010, 32'h14, 32'h0, 32'hBEEFAA77, 1'b0, 3, 0});

        // Held req with a changing LW address each cycle: only every third one is taken.
        words[0] = 32'hCAFEF00D; words[1] = 32'h11111111;
        words[2] = 32'h22222222; words[3] = 32'h33333333;
        cnt = 0;
        for (int c = 0; c < 16; c++) begin
            if (bb_q.size() > 0 && bb_q[0].due == c) begin
                bb_t b;
                b = bb_q.pop_front();
                check("b2b_done", 32'(done), 32'(1));
                check("b2b_rdata", rdata, b.val);
            end else begin
                check("b2b_no_done", 32'(done), 32'(0));
            end
            if (c < 12) begin
                req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'(c % 4) * 4;
                if (cnt == 0) begin
                    bb_q.push_back('{words[c % 4], c + 3});
                    cnt = 2;
                end else begin
                    cnt--;
                end
            end else begin
                req = 1'b0;
                if (cnt > 0) cnt--;
            end
            @(posedge clk); #1;
        end
        check("b2b_drained", 32'(bb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
